// File: rtl/spart_pkg.sv
// Shared types and register-address constants for the SPART bus arbiter.
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [1:0] ADDR_TXRX    = 2'b00;
    localparam logic [1:0] ADDR_STATUS  = 2'b01;
    localparam logic [1:0] ADDR_DB_LOW  = 2'b10;
    localparam logic [1:0] ADDR_DB_HIGH = 2'b11;

endpackage

// File: rtl/spart_bus_arb_if.sv
// Signal bundle between the requesters, the arbiter and the SPART register port.
// Defining SPART_ARB_LOCK_EN adds the per-requester lock input.
interface spart_bus_arb_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_rw;
    logic [2*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic [7:0]           rdata;
    logic                 iocs;
    logic                 iorw;
    logic [1:0]           ioaddr;
    logic [7:0]           db_out;
    logic                 db_oe;
    logic [7:0]           db_in;
    logic                 rda;
    logic                 tbr;
`ifdef SPART_ARB_LOCK_EN
    logic [NUM_REQ-1:0]   lock;

    modport slave (
        input  req, req_rw, req_addr, req_wdata, lock, db_in, rda, tbr,
        output gnt, done, rdata, iocs, iorw, ioaddr, db_out, db_oe
    );

    modport master (
        output req, req_rw, req_addr, req_wdata, lock, db_in, rda, tbr,
        input  gnt, done, rdata, iocs, iorw, ioaddr, db_out, db_oe
    );
`else
    modport slave (
        input  req, req_rw, req_addr, req_wdata, db_in, rda, tbr,
        output gnt, done, rdata, iocs, iorw, ioaddr, db_out, db_oe
    );

    modport master (
        output req, req_rw, req_addr, req_wdata, db_in, rda, tbr,
        input  gnt, done, rdata, iocs, iorw, ioaddr, db_out, db_oe
    );
`endif
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of elig searching upward
// from rr_ptr+1 with wrap-around.
module rr_pick #(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [IdxW-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IdxW-1:0]    index
);

    int unsigned cand;
    logic        found;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(rr_ptr) + off) % NUM_REQ;
            if (!found && elig[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/spart_bus_arb.sv
// Round-robin arbiter sequencing one SPART register access per grant (IDLE/ACCESS/DONE).
// Defining SPART_ARB_LOCK_EN lets a locked winner keep the bus for its next access.
module spart_bus_arb
    import spart_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input logic            clk,
    input logic            rst,
    spart_bus_arb_if.slave bus
);

    state_t             state_q;
    logic [IdxW-1:0]    rr_ptr_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic [7:0]         rdata_q;
    logic               iocs_q;
    logic               iorw_q;
    logic [1:0]         ioaddr_q;
    logic [7:0]         db_out_q;
    logic               db_oe_q;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IdxW-1:0]    pick_idx;
    logic [NUM_REQ-1:0] sel_gnt;
    logic [IdxW-1:0]    sel_idx;
`ifdef SPART_ARB_LOCK_EN
    logic               lock_q;
`endif

    // Data-register accesses wait for the SPART; config/status never do.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = bus.req[i] & ((bus.req_addr[2*i +: 2] != ADDR_TXRX) |
                                    (bus.req_rw[i] ? bus.rda : bus.tbr));
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .elig   (elig),
        .rr_ptr (rr_ptr_q),
        .grant  (pick_gnt),
        .index  (pick_idx)
    );

    // rr_ptr_q always holds the last winner, so the lock override re-grants it.
    always_comb begin
        sel_gnt = pick_gnt;
        sel_idx = pick_idx;
`ifdef SPART_ARB_LOCK_EN
        if (lock_q && elig[rr_ptr_q]) begin
            sel_gnt = NUM_REQ'(1) << rr_ptr_q;
            sel_idx = rr_ptr_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= IdxW'(NUM_REQ - 1);
            gnt_q    <= '0;
            done_q   <= '0;
            rdata_q  <= 8'h00;
            iocs_q   <= 1'b0;
            iorw_q   <= 1'b1;
            ioaddr_q <= ADDR_TXRX;
            db_out_q <= 8'h00;
            db_oe_q  <= 1'b0;
`ifdef SPART_ARB_LOCK_EN
            lock_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|elig) begin
                        gnt_q    <= sel_gnt;
                        iocs_q   <= 1'b1;
                        iorw_q   <= bus.req_rw[sel_idx];
                        ioaddr_q <= bus.req_addr[2*sel_idx +: 2];
                        db_out_q <= bus.req_wdata[8*sel_idx +: 8];
                        db_oe_q  <= ~bus.req_rw[sel_idx];
                        rr_ptr_q <= sel_idx;
                        state_q  <= ACCESS;
                    end
`ifdef SPART_ARB_LOCK_EN
                    lock_q <= 1'b0;
`endif
                end
                ACCESS: begin
                    iocs_q  <= 1'b0;
                    db_oe_q <= 1'b0;
                    done_q  <= gnt_q;
                    if (iorw_q) begin
                        rdata_q <= bus.db_in;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    done_q   <= '0;
                    gnt_q    <= '0;
                    iorw_q   <= 1'b1;
                    ioaddr_q <= ADDR_TXRX;
                    db_out_q <= 8'h00;
`ifdef SPART_ARB_LOCK_EN
                    lock_q   <= bus.lock[rr_ptr_q];
`endif
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.rdata  = rdata_q;
    assign bus.iocs   = iocs_q;
    assign bus.iorw   = iorw_q;
    assign bus.ioaddr = ioaddr_q;
    assign bus.db_out = db_out_q;
    assign bus.db_oe  = db_oe_q;

endmodule

// File: tb/tb_spart_bus_arb.sv
// Scoreboard bench for spart_bus_arb: directed stimulus pushes expected bus
// accesses and completions; a negedge monitor pops and compares them.
module tb_spart_bus_arb;

    typedef struct {
        logic [1:0] gnt;
        logic       rw;
        logic [1:0] addr;
        logic [7:0] wd;
        int         cyc;
    } acc_t;

    typedef struct {
        logic [1:0] dn;
        logic [7:0] rd;
        int         cyc;
    } dn_t;

    logic clk;
    logic rst;
    int   cyc;
    int   vectors;
    int   miscompares;
    int   c;
    acc_t acc_q[$];
    dn_t  dn_q[$];
    acc_t mon_a;
    dn_t  mon_d;

    spart_bus_arb_if #(.NUM_REQ(2)) bus ();

    spart_bus_arb #(
        .NUM_REQ (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic r, input logic rw, input logic [1:0] a,
                           input logic [7:0] d);
        bus.req[i]            = r;
        bus.req_rw[i]         = rw;
        bus.req_addr[2*i +: 2] = a;
        bus.req_wdata[8*i +: 8] = d;
    endtask

    task automatic exp_acc(input logic [1:0] g, input logic rw, input logic [1:0] a,
                           input logic [7:0] d, input int at);
        acc_t e;
        e.gnt = g; e.rw = rw; e.addr = a; e.wd = d; e.cyc = at;
        acc_q.push_back(e);
    endtask

    task automatic exp_done(input logic [1:0] dn, input logic [7:0] rd, input int at);
        dn_t e;
        e.dn = dn; e.rd = rd; e.cyc = at;
        dn_q.push_back(e);
    endtask

    // Monitor: every access and completion the DUT presents must be expected.
    always @(negedge clk) begin
        if (bus.iocs === 1'b1) begin
            if (acc_q.size() == 0) begin
                chk("unexpected_access", 32'(bus.gnt), 32'(0));
            end else begin
                mon_a = acc_q.pop_front();
                chk("access_bus",
                    32'({bus.gnt, bus.iorw, bus.ioaddr, bus.db_oe,
                         bus.iorw ? 8'h00 : bus.db_out}),
                    32'({mon_a.gnt, mon_a.rw, mon_a.addr, ~mon_a.rw,
                         mon_a.rw ? 8'h00 : mon_a.wd}));
                chk("access_cycle", 32'(cyc), 32'(mon_a.cyc));
            end
        end
        if (|bus.done) begin
            if (dn_q.size() == 0) begin
                chk("unexpected_done", 32'(bus.done), 32'(0));
            end else begin
                mon_d = dn_q.pop_front();
                chk("done_rdata", 32'({bus.done, bus.gnt, bus.rdata}),
                    32'({mon_d.dn, mon_d.dn, mon_d.rd}));
                chk("done_cycle", 32'(cyc), 32'(mon_d.cyc));
            end
        end
        if (bus.db_oe === 1'b1 && bus.iocs !== 1'b1) begin
            chk("db_oe_outside_access", 32'(bus.db_oe), 32'(0));
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.req       = '0;
        bus.req_rw    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.db_in     = 8'h00;
        bus.rda       = 1'b0;
        bus.tbr       = 1'b0;
`ifdef SPART_ARB_LOCK_EN
        bus.lock      = '0;
`endif
        step(3);
        chk("reset_state",
            32'({bus.gnt, bus.done, bus.rdata, bus.iocs, bus.iorw, bus.ioaddr, bus.db_out,
                 bus.db_oe}),
            32'({2'b00, 2'b00, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00, 1'b0}));
        rst = 1'b0;
        step(1);

        // Divisor-low write from requester 0.
        c = cyc;
        set_req(0, 1'b1, 1'b0, 2'b10, 8'h8A);
        exp_acc(2'b01, 1'b0, 2'b10, 8'h8A, c + 1);
        exp_done(2'b01, 8'h00, c + 2);
        step(2);
        set_req(0, 1'b0, 1'b0, 2'b10, 8'h8A);
        step(1);

        // RX read from requester 1 with data available.
        c = cyc;
        bus.rda   = 1'b1;
        bus.db_in = 8'h41;
        set_req(1, 1'b1, 1'b1, 2'b00, 8'h00);
        exp_acc(2'b10, 1'b1, 2'b00, 8'h00, c + 1);
        exp_done(2'b10, 8'h41, c + 2);
        step(2);
        set_req(1, 1'b0, 1'b1, 2'b00, 8'h00);
        bus.rda = 1'b0;
        step(1);

        // TX write blocked by tbr=0 while a status read goes ahead.
        c = cyc;
        bus.db_in = 8'h03;
        set_req(0, 1'b1, 1'b0, 2'b00, 8'h55);
        set_req(1, 1'b1, 1'b1, 2'b01, 8'h00);
        exp_acc(2'b10, 1'b1, 2'b01, 8'h00, c + 1);
        exp_done(2'b10, 8'h03, c + 2);
        step(2);
        set_req(1, 1'b0, 1'b1, 2'b01, 8'h00);
        step(3);
        bus.tbr = 1'b1;
        exp_acc(2'b01, 1'b0, 2'b00, 8'h55, c + 6);
        exp_done(2'b01, 8'h03, c + 7);
        step(2);
        set_req(0, 1'b0, 1'b0, 2'b00, 8'h55);
        step(1);

        // Both requesting continuously: strict alternation every 3 cycles.
        c = cyc;
        set_req(0, 1'b1, 1'b0, 2'b11, 8'h11);
        set_req(1, 1'b1, 1'b0, 2'b11, 8'h22);
        for (int k = 0; k < 4; k++) begin
            exp_acc((k % 2 == 0) ? 2'b10 : 2'b01, 1'b0, 2'b11,
                    (k % 2 == 0) ? 8'h22 : 8'h11, c + 1 + 3 * k);
            exp_done((k % 2 == 0) ? 2'b10 : 2'b01, 8'h03, c + 2 + 3 * k);
        end
        step(11);
        bus.req = 2'b00;
        step(1);

        // Reset during ACCESS aborts the access; pointer restarts at requester 0.
        c = cyc;
        set_req(0, 1'b1, 1'b0, 2'b10, 8'h5A);
        exp_acc(2'b01, 1'b0, 2'b10, 8'h5A, c + 1);
        step(1);
        rst = 1'b1;
        set_req(1, 1'b1, 1'b0, 2'b10, 8'h99);
        step(1);
        chk("rst_abort", 32'({bus.iocs, bus.db_oe, bus.gnt, bus.done}),
            32'({1'b0, 1'b0, 2'b00, 2'b00}));
        rst = 1'b0;
        exp_acc(2'b01, 1'b0, 2'b10, 8'h5A, c + 3);
        exp_done(2'b01, 8'h00, c + 4);
        exp_acc(2'b10, 1'b0, 2'b10, 8'h99, c + 6);
        exp_done(2'b10, 8'h00, c + 7);
        step(2);
        set_req(0, 1'b0, 1'b0, 2'b10, 8'h5A);
        step(3);
        set_req(1, 1'b0, 1'b0, 2'b10, 8'h99);
        step(1);

        // Divisor pair from requester 1 while requester 0 also wants the bus.
        c = cyc;
        set_req(1, 1'b1, 1'b0, 2'b10, 8'hB1);
`ifdef SPART_ARB_LOCK_EN
        bus.lock[1] = 1'b1;
`endif
        exp_acc(2'b10, 1'b0, 2'b10, 8'hB1, c + 1);
        exp_done(2'b10, 8'h00, c + 2);
`ifdef SPART_ARB_LOCK_EN
        exp_acc(2'b10, 1'b0, 2'b11, 8'hB2, c + 4);
        exp_done(2'b10, 8'h00, c + 5);
        exp_acc(2'b01, 1'b0, 2'b01, 8'h77, c + 7);
        exp_done(2'b01, 8'h00, c + 8);
`else
        exp_acc(2'b01, 1'b0, 2'b01, 8'h77, c + 4);
        exp_done(2'b01, 8'h00, c + 5);
        exp_acc(2'b10, 1'b0, 2'b11, 8'hB2, c + 7);
        exp_done(2'b10, 8'h00, c + 8);
`endif
        step(1);
        set_req(0, 1'b1, 1'b0, 2'b01, 8'h77);
        step(1);
        set_req(1, 1'b1, 1'b0, 2'b11, 8'hB2);
        step(1);
`ifdef SPART_ARB_LOCK_EN
        bus.lock[1] = 1'b0;
`endif
`ifdef SPART_ARB_LOCK_EN
        step(2);
        set_req(1, 1'b0, 1'b0, 2'b11, 8'hB2);
        step(3);
        set_req(0, 1'b0, 1'b0, 2'b01, 8'h77);
`else
        step(2);
        set_req(0, 1'b0, 1'b0, 2'b01, 8'h77);
        step(3);
        set_req(1, 1'b0, 1'b0, 2'b11, 8'hB2);
`endif

        // Drain with a bounded wait; anything left over was never presented.
        for (int k = 0; k < 20; k++) begin
            if (acc_q.size() != 0 || dn_q.size() != 0) step(1);
        end
        step(4);
        chk("drain_access", 32'(acc_q.size()), 32'(0));
        chk("drain_done", 32'(dn_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
